// File: rtl/fib_pkg.sv
// Shared types and default parameters for the Fibonacci sequence generator.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned FIB_WIDTH       = 8;
    localparam int unsigned FIB_CNT_W       = 6;
    localparam bit          FIB_STOP_ON_OVF = 1'b1;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder, the building block of the ripple-carry adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rcadder_nb.sv
// WIDTH-bit ripple-carry adder with carry-in tied low; cout flags modulo wrap.
module rcadder_nb #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/fib_seq_gen.sv
// Handshaked Fibonacci term streamer: emits F0..F(n-1) over valid/ready,
// with adder-carry overflow detection that either stops or wraps the run.
module fib_seq_gen
    import fib_pkg::*;
#(
    parameter int unsigned WIDTH       = FIB_WIDTH,
    parameter int unsigned CNT_W       = FIB_CNT_W,
    parameter bit          STOP_ON_OVF = FIB_STOP_ON_OVF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_terms,
    output logic             ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] term,
    output logic [CNT_W-1:0] index,
    output logic             done,
    output logic             overflow
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, sum;
    logic             cout, b_ovf;
    logic [CNT_W-1:0] idx, n_q;
    logic             ovf_q;
    logic             hs, last;

    rcadder_nb #(.WIDTH(WIDTH)) u_add (
        .a    (a_q),
        .b    (b_q),
        .sum  (sum),
        .cout (cout)
    );

    assign hs   = (state == RUN) && out_ready;
    assign last = (idx == n_q - CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (n_terms == '0) ? DONE : RUN;
            RUN:  if (hs && (last || (b_ovf && STOP_ON_OVF))) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready     = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:    ready     = 1'b1;
            RUN:     out_valid = 1'b1;
            DONE:    done      = 1'b1;
            default: ready     = 1'b0;
        endcase
    end

    // b runs one term ahead; its carry only matters once it is promoted to a.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= WIDTH'(1);
            b_ovf <= 1'b0;
            idx   <= '0;
            n_q   <= '0;
            ovf_q <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                n_q   <= n_terms;
                ovf_q <= 1'b0;
                a_q   <= '0;
                b_q   <= WIDTH'(1);
                b_ovf <= 1'b0;
                idx   <= '0;
            end
        end else if (hs && !last) begin
            if (b_ovf && STOP_ON_OVF) begin
                ovf_q <= 1'b1;
            end else begin
                a_q   <= b_q;
                b_q   <= sum;
                b_ovf <= cout;
                idx   <= idx + CNT_W'(1);
                if (b_ovf) ovf_q <= 1'b1;
            end
        end
    end

    assign term     = a_q;
    assign index    = idx;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed bench for fib_seq_gen: one stop-mode and one wrap-mode instance.
module tb_fib_seq_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic [5:0] n_terms;
    logic       out_ready;
    logic       sel;

    logic       p_ready, p_valid, p_done, p_ovf;
    logic [7:0] p_term;
    logic [5:0] p_index;
    logic       w_ready, w_valid, w_done, w_ovf;
    logic [7:0] w_term;
    logic [5:0] w_index;

    logic       ready, out_valid, done, overflow;
    logic [7:0] term;
    logic [5:0] index;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    int unsigned fib_exp [16] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121, 98};
    int unsigned stalls [5]   = '{0, 7, 3, 7, 1};

    fib_seq_gen #(.WIDTH(8), .CNT_W(6), .STOP_ON_OVF(1'b1)) u_stop (
        .clk       (clk),
        .rst       (rst),
        .start     (start & ~sel),
        .n_terms   (n_terms),
        .ready     (p_ready),
        .out_valid (p_valid),
        .out_ready (out_ready),
        .term      (p_term),
        .index     (p_index),
        .done      (p_done),
        .overflow  (p_ovf)
    );

    fib_seq_gen #(.WIDTH(8), .CNT_W(6), .STOP_ON_OVF(1'b0)) u_wrap (
        .clk       (clk),
        .rst       (rst),
        .start     (start & sel),
        .n_terms   (n_terms),
        .ready     (w_ready),
        .out_valid (w_valid),
        .out_ready (out_ready),
        .term      (w_term),
        .index     (w_index),
        .done      (w_done),
        .overflow  (w_ovf)
    );

    assign ready     = sel ? w_ready : p_ready;
    assign out_valid = sel ? w_valid : p_valid;
    assign done      = sel ? w_done  : p_done;
    assign overflow  = sel ? w_ovf   : p_ovf;
    assign term      = sel ? w_term  : p_term;
    assign index     = sel ? w_index : p_index;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".ready"},     32'(ready),     1);
        chk({tag, ".out_valid"}, 32'(out_valid), 0);
        chk({tag, ".term"},      32'(term),      0);
        chk({tag, ".index"},     32'(index),     0);
        chk({tag, ".done"},      32'(done),      0);
        chk({tag, ".overflow"},  32'(overflow),  0);
    endtask

    task automatic start_run(input int unsigned n);
        start   = 1'b1;
        n_terms = 6'(n);
        tick();
        start   = 1'b0;
        n_terms = 6'd63;
    endtask

    task automatic run_stream(input string tag, input int unsigned n,
                              input int unsigned ovf_from, input bit ovf_final);
        out_ready = 1'b1;
        for (int unsigned i = 0; i < n; i++) begin
            chk($sformatf("%s.valid[%0d]", tag, i), 32'(out_valid), 1);
            chk($sformatf("%s.term[%0d]",  tag, i), 32'(term),      fib_exp[i]);
            chk($sformatf("%s.index[%0d]", tag, i), 32'(index),     i);
            chk($sformatf("%s.ovf[%0d]",   tag, i), 32'(overflow),  32'(i >= ovf_from));
            chk($sformatf("%s.done[%0d]",  tag, i), 32'(done),      0);
            tick();
        end
        chk({tag, ".done"},       32'(done),      1);
        chk({tag, ".done_valid"}, 32'(out_valid), 0);
        chk({tag, ".done_ready"}, 32'(ready),     0);
        chk({tag, ".done_ovf"},   32'(overflow),  32'(ovf_final));
        tick();
        chk({tag, ".idle_ready"}, 32'(ready),     1);
        chk({tag, ".idle_done"},  32'(done),      0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        n_terms   = '0;
        out_ready = 1'b0;
        sel       = 1'b0;
        repeat (3) tick();
        check_idle("reset");
        rst = 1'b0;
        tick();
        check_idle("post_reset");

        start_run(10);
        run_stream("n10", 10, 99, 1'b0);

        start_run(20);
        run_stream("stop20", 14, 99, 1'b1);

        sel = 1'b1;
        start_run(16);
        run_stream("wrap16", 16, 14, 1'b1);
        sel = 1'b0;

        // Backpressure with start pulses that must be ignored mid-run.
        start_run(5);
        for (int unsigned i = 0; i < 5; i++) begin
            out_ready = 1'b0;
            for (int unsigned s = 0; s < stalls[i]; s++) begin
                start   = s[0];
                n_terms = 6'd2;
                tick();
                chk($sformatf("stall.term[%0d.%0d]",  i, s), 32'(term),      fib_exp[i]);
                chk($sformatf("stall.index[%0d.%0d]", i, s), 32'(index),     i);
                chk($sformatf("stall.valid[%0d.%0d]", i, s), 32'(out_valid), 1);
                chk($sformatf("stall.done[%0d.%0d]",  i, s), 32'(done),      0);
            end
            start     = 1'b0;
            out_ready = 1'b1;
            chk($sformatf("stall.hs_term[%0d]",  i), 32'(term),  fib_exp[i]);
            chk($sformatf("stall.hs_index[%0d]", i), 32'(index), i);
            tick();
        end
        chk("stall.done",       32'(done),      1);
        tick();
        chk("stall.done_once",  32'(done),      0);
        chk("stall.idle_ready", 32'(ready),     1);
        tick();
        chk("stall.no_rerun",   32'(out_valid), 0);

        start_run(0);
        chk("zero.valid",      32'(out_valid), 0);
        chk("zero.done",       32'(done),      1);
        tick();
        chk("zero.idle_ready", 32'(ready),     1);
        chk("zero.idle_done",  32'(done),      0);

        start_run(10);
        repeat (3) tick();
        chk("abort.index_before", 32'(index), 3);
        chk("abort.term_before",  32'(term),  2);
        #2 rst = 1'b1;
        #1 check_idle("abort");
        #2 rst = 1'b0;
        tick();
        check_idle("abort_idle");
        start_run(3);
        run_stream("restart", 3, 99, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
